// File: rtl/execute_muldiv_seq_if.sv
// Handshake and data bundle between decode/EX and the RV32M mul/div sequencer.
interface execute_muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] opv1;
    logic [XLEN-1:0] opv2;
    logic            flush;
    logic            stallreq;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, opv1, opv2, flush,
        input  stallreq, busy, done, result
    );

    modport slave (
        input  start, op, opv1, opv2, flush,
        output stallreq, busy, done, result
    );
endinterface

// File: rtl/execute_muldiv_seq.sv
// Multi-cycle RV32M sequencer: shift-add multiply and restoring divide on one shared
// 2*XLEN accumulator, with sign handling done up front (magnitudes) and in FIX.
module execute_muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic clk,
    input logic rst_n,
    execute_muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    localparam logic [XLEN-1:0]   One    = XLEN'(1);
    localparam logic [2*XLEN-1:0] OneW   = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]   MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              fast_q, fast_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            sgn1, sgn2, div0, ovf;
    logic [XLEN-1:0] mag1, mag2;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] div_rem;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        sgn1 = bus.opv1[XLEN-1] & (bus.op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
        sgn2 = bus.opv2[XLEN-1] & (bus.op inside {3'd0, 3'd1, 3'd4, 3'd6});
        mag1 = sgn1 ? (~bus.opv1 + One) : bus.opv1;
        mag2 = sgn2 ? (~bus.opv2 + One) : bus.opv2;
        div0 = bus.op[2] && (bus.opv2 == '0);
        ovf  = (bus.op inside {3'd4, 3'd6}) && (bus.opv1 == MinNeg) && (bus.opv2 == '1);
    end

    // One datapath step of each kind; the FSM picks which one to commit.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        div_rem   = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        prod_fix  = neg_q ? (~acc_q + OneW) : acc_q;
        quo_fix   = neg_q ? (~acc_q[XLEN-1:0] + One) : acc_q[XLEN-1:0];
        rem_fix   = neg_q ? (~acc_q[2*XLEN-1:XLEN] + One) : acc_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        op_d     = op_q;
        neg_d    = neg_q;
        fast_d   = fast_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    cnt_d   = '0;
                    fast_d  = div0 | ovf;
                    state_d = (div0 | ovf) ? StFix : StCalc;
                    if (!bus.op[2]) begin
                        mcand_d = mag1;
                        acc_d   = {{XLEN{1'b0}}, mag2};
                        neg_d   = sgn1 ^ sgn2;
                    end else begin
                        mcand_d = mag2;
                        acc_d   = {{XLEN{1'b0}}, mag1};
                        neg_d   = bus.op[1] ? sgn1 : (sgn1 ^ sgn2);
                    end
                    // Fast-path answer is parked in the low half for FIX to pick up.
                    if (div0) begin
                        acc_d = {{XLEN{1'b0}}, (bus.op[1] ? bus.opv1 : '1)};
                    end else if (ovf) begin
                        acc_d = {{XLEN{1'b0}}, (bus.op[1] ? '0 : MinNeg)};
                    end
                end
            end
            StCalc: begin
                acc_d = op_q[2] ? {div_rem, acc_q[XLEN-2:0], ~div_diff[XLEN]}
                                : {mul_sum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    cnt_d   = '0;
                    state_d = StFix;
                end
            end
            StFix: begin
                if (fast_q) begin
                    result_d = acc_q[XLEN-1:0];
                end else begin
                    unique case (op_q)
                        3'd0:                result_d = prod_fix[XLEN-1:0];
                        3'd1, 3'd2, 3'd3:    result_d = prod_fix[2*XLEN-1:XLEN];
                        3'd4, 3'd5:          result_d = quo_fix;
                        default:             result_d = rem_fix;
                    endcase
                end
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
        // Flush kills everything, including the result update in FIX.
        if (bus.flush) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            fast_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            fast_q   <= fast_d;
            result_q <= result_d;
        end
    end

    assign bus.stallreq = !bus.flush && (((state_q == StIdle) && bus.start) ||
                                         (state_q == StCalc) || (state_q == StFix));
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone) && !bus.flush;
    assign bus.result   = result_q;
endmodule
